shift_seq_ctrl: RTL

Controller that sequences the 8-bit board shift-register datapath (parallel load from switches, right shift with MSB fill, LSB capture into the green-LED register). It turns three raw active-low push-buttons into single-cycle `load` and `shift` strobes. It adds an automatic mode that performs a full NBITS-bit shift-out at a programmable rate. It sits between the board buttons/switches and the register datapath, and exports a shift count and state for the hex displays.

---
 rtl/shift_seq_pkg.sv | 24 ++
 rtl/btn_edge.sv | 47 ++++
 rtl/shift_seq_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift-register sequencer
//
// Purpose: FSM state encoding, default sizing constants and the saturating
//          shift-count helper used by shift_seq_ctrl.
// Ports:   none (package)

package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } seq_state_t;

    localparam int DEF_NBITS    = 8;
    localparam int DEF_STEP_DIV = 25_000_000;
    localparam int CNT_W        = $clog2(DEF_NBITS + 1);

    // Increment that sticks once the limit is reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        return (value >= limit) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button synchronizer and press detector
//
// Purpose: brings a raw active-low button into the clk domain through two
//          flops and flags one cycle per press (falling edge of the
//          synchronized level).
// Ports:   clk   - system clock
//          rst   - synchronous active-high reset
//          btn   - raw active-low button, asynchronous to clk
//          press - high for one cycle per press

module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync0;
    logic sync1;
    logic prev;
    logic settled;
    logic armed;

    // Detection stays disarmed until a real released level has passed the
    // first synchronizer stage after reset. A button held through reset
    // therefore needs a release before it can produce a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            prev    <= 1'b1;
            settled <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            prev    <= sync1;
            settled <= 1'b1;
            if (settled && sync0) begin
                armed <= 1'b1;
            end
        end
    end

    assign press = armed & prev & ~sync1;

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load/shift sequencer for the board shift-register datapath
//
// Purpose: turns three raw buttons into single-cycle load/shift strobes and
//          runs automatic NBITS-shift sequences at a programmable rate.
//          Build option SHIFT_SEQ_ROTATE_EN: when defined the datapath rotates
//          (shift_in = q_lsb); otherwise shift_in = fill_in.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          load_btn          - raw active-low parallel-load button
//          step_btn          - raw active-low manual single-shift button
//          run_btn           - raw active-low start/abort button
//          mode              - 0 manual, 1 automatic (sampled at run start)
//          fill_in, q_lsb    - MSB fill switch, datapath bit 0
//          load, shift       - one-cycle strobes to the datapath
//          shift_in          - bit shifted into the datapath MSB
//          busy, done        - run in progress, run-complete pulse
//          count, state      - shifts since last load (saturating), FSM state

module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int NBITS    = DEF_NBITS,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_btn,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             mode,
    input  logic             fill_in,
    input  logic             q_lsb,
    output logic             load,
    output logic             shift,
    output logic             shift_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state
);

    localparam int              PW         = $clog2(STEP_DIV);
    localparam logic [PW-1:0]   PRESC_TERM = PW'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(NBITS);

    logic load_press;
    logic step_press;
    logic run_press;

    btn_edge u_load_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (load_btn),
        .press (load_press)
    );

    btn_edge u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .press (step_press)
    );

    btn_edge u_run_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (run_btn),
        .press (run_press)
    );

    seq_state_t       st;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_IDLE;
            load    <= 1'b0;
            shift   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            presc   <= '0;
            run_cnt <= '0;
        end else begin
            load  <= 1'b0;
            shift <= 1'b0;
            done  <= 1'b0;
            if (load_press) begin
                // Load wins over everything, including a terminal shift.
                load    <= 1'b1;
                count   <= '0;
                presc   <= '0;
                run_cnt <= '0;
                st      <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        busy <= 1'b0;
                        if (run_press && mode) begin
                            st      <= ST_RUN;
                            busy    <= 1'b1;
                            presc   <= '0;
                            run_cnt <= '0;
                        end else if (step_press && !run_press) begin
                            shift <= 1'b1;
                            count <= sat_inc(count, CNT_LIM);
                        end
                    end
                    ST_RUN: begin
                        if (run_press) begin
                            st   <= ST_IDLE;
                            busy <= 1'b0;
                        end else if (run_cnt == CNT_LIM) begin
                            // One cycle after the last shift: close the run.
                            st   <= ST_IDLE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else if (presc == PRESC_TERM) begin
                            presc   <= '0;
                            shift   <= 1'b1;
                            count   <= sat_inc(count, CNT_LIM);
                            run_cnt <= run_cnt + CNT_W'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: begin
                        st   <= ST_IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic unused_fill_in;
    assign unused_fill_in = fill_in;
    assign shift_in       = q_lsb;
`else
    logic unused_q_lsb;
    assign unused_q_lsb = q_lsb;
    assign shift_in     = fill_in;
`endif

endmodule
